// File: rtl/vocab_matcher.sv
// vocab_matcher: char-serial exact (or, with VOCAB_MATCHER_PREFIX_EN, prefix) search of a writable null-terminated vocabulary
module vocab_matcher #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int MAX_LEN = 3,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic [MAX_LEN*DATA_WIDTH-1:0] word,
`ifdef VOCAB_MATCHER_PREFIX_EN
  input  logic prefix_mode,
`endif
  input  logic wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic busy,
  output logic done,
  output logic found,
  output logic [ADDR_WIDTH-1:0] token_id,
  output logic [ADDR_WIDTH-1:0] match_addr
);
  localparam int AIW = $clog2(MAX_LEN + 1);
  typedef enum logic [1:0] {IDLE, CMP, SKIP, DONE} state_t;
  state_t state, state_n;
  logic [DATA_WIDTH-1:0] vocab [DEPTH];
  logic [MAX_LEN*DATA_WIDTH-1:0] wreg;
  logic [ADDR_WIDTH-1:0] av, av_n, tok, tok_n, wstart, wstart_n;
  logic [AIW-1:0] ai, ai_n;
  logic [DATA_WIDTH-1:0] v, c;
  logic last, hit, pfx, go;
  assign v = vocab[av];
  assign last = av == ADDR_WIDTH'(DEPTH - 1);
  assign go = state == IDLE && start;
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_comb begin
    c = '0;
    for (int i = 0; i < MAX_LEN; i++)
      c = ai == AIW'(i) ? wreg[i*DATA_WIDTH +: DATA_WIDTH] : c;
  end
`ifdef VOCAB_MATCHER_PREFIX_EN
  logic pm;
  always_ff @(posedge clk)
    if (rst) pm <= 1'b0;
    else if (go) pm <= prefix_mode;
  assign pfx = pm && c == '0 && ai != '0 && v != '0;
`else
  assign pfx = 1'b0;
`endif
  always_comb begin
    state_n = state;
    av_n = av;
    ai_n = ai;
    tok_n = tok;
    wstart_n = wstart;
    hit = 1'b0;
    case (state)
      IDLE: if (start) begin
        state_n = CMP;
        av_n = '0;
        ai_n = '0;
        tok_n = '0;
        wstart_n = '0;
      end
      CMP: if (ai == '0 && v == '0) state_n = DONE;
      else if ((v == c && c == '0) || pfx) begin
        state_n = DONE;
        hit = 1'b1;
      end
      else if (last) state_n = DONE;
      else if (v == c) begin
        av_n = av + 1'b1;
        ai_n = ai + 1'b1;
      end
      else if (v == '0) begin
        av_n = av + 1'b1;
        ai_n = '0;
        tok_n = tok + 1'b1;
        wstart_n = av + 1'b1;
      end
      else begin
        av_n = av + 1'b1;
        state_n = SKIP;
      end
      SKIP: if (last) state_n = DONE;
      else if (v == '0) begin
        av_n = av + 1'b1;
        ai_n = '0;
        tok_n = tok + 1'b1;
        wstart_n = av + 1'b1;
        state_n = CMP;
      end
      else av_n = av + 1'b1;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) for (int i = 0; i < DEPTH; i++) vocab[i] <= '0;
    else if (state == IDLE && wr_en) vocab[wr_addr] <= wr_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      wreg <= '0;
      av <= '0;
      ai <= '0;
      tok <= '0;
      wstart <= '0;
      found <= 1'b0;
      token_id <= '0;
      match_addr <= '0;
    end else begin
      state <= state_n;
      av <= av_n;
      ai <= ai_n;
      tok <= tok_n;
      wstart <= wstart_n;
      if (go) begin
        wreg <= word;
        found <= 1'b0;
      end
      if (hit) begin
        found <= 1'b1;
        token_id <= tok;
        match_addr <= wstart;
      end
    end
  end
endmodule

// File: tb/tb_vocab_matcher.sv
// tb_vocab_matcher: table-driven and scoreboard checks of vocab_matcher
module tb_vocab_matcher;
  localparam int DW = 8, DEPTH = 16, ML = 3, AW = 4;
  logic clk = 1'b0;
  logic rst, start, wr_en, busy, done, found;
  logic [ML*DW-1:0] word;
  logic [AW-1:0] wr_addr, token_id, match_addr;
  logic [DW-1:0] wr_data;
`ifdef VOCAB_MATCHER_PREFIX_EN
  logic prefix_mode;
`endif
  typedef struct {
    logic f;
    logic [AW-1:0] t;
    logic [AW-1:0] a;
    int e;
  } exp_t;
  typedef struct {
    string nm;
    logic [23:0] w;
    logic f;
    logic [AW-1:0] t;
    logic [AW-1:0] a;
    int e;
  } vec_t;
  exp_t sb[$];
  vec_t tbl[6];
  int total = 0, bad = 0;
  logic [AW-1:0] held_t = '0, held_a = '0;
  vocab_matcher dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .word(word),
`ifdef VOCAB_MATCHER_PREFIX_EN
    .prefix_mode(prefix_mode),
`endif
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .busy(busy),
    .done(done),
    .found(found),
    .token_id(token_id),
    .match_addr(match_addr)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, want);
    end
  endtask
  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_en = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(posedge clk);
    #1 wr_en = 1'b0;
  endtask
  task automatic launch(input logic [23:0] w, input logic f, input logic [AW-1:0] t, input logic [AW-1:0] a, input int e);
    exp_t x;
    if (f) begin
      held_t = t;
      held_a = a;
    end
    x.f = f;
    x.t = held_t;
    x.a = held_a;
    x.e = e;
    sb.push_back(x);
    word = w;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("busy_after_start", {31'd0, busy}, 1);
  endtask
  task automatic collect(input string nm, input int e0);
    int n;
    exp_t x;
    n = e0;
    while (!done && n < 300) begin
      @(posedge clk);
      #1 n++;
    end
    x = sb.pop_front();
    chk({nm, "_done"}, {31'd0, done}, 1);
    chk({nm, "_found"}, {31'd0, found}, {31'd0, x.f});
    chk({nm, "_token"}, {28'd0, token_id}, {28'd0, x.t});
    chk({nm, "_addr"}, {28'd0, match_addr}, {28'd0, x.a});
    chk({nm, "_edges"}, n, x.e);
    @(posedge clk);
    #1;
    chk({nm, "_done_pulse"}, {31'd0, done}, 0);
    chk({nm, "_busy_fall"}, {31'd0, busy}, 0);
  endtask
  task automatic load_ab_cd();
    wr(0, 8'h61);
    wr(1, 8'h62);
    wr(2, 8'h00);
    wr(3, 8'h63);
    wr(4, 8'h64);
    wr(5, 8'h00);
    wr(6, 8'h00);
  endtask
  initial begin
    tbl[0] = '{"cd",    24'h006463, 1'b1, 4'd1, 4'd3, 7};
    tbl[1] = '{"ce",    24'h006563, 1'b0, 4'd0, 4'd0, 8};
    tbl[2] = '{"ab",    24'h006261, 1'b1, 4'd0, 4'd0, 4};
    tbl[3] = '{"a",     24'h000061, 1'b0, 4'd0, 4'd0, 8};
    tbl[4] = '{"abc",   24'h636261, 1'b0, 4'd0, 4'd0, 8};
    tbl[5] = '{"empty", 24'h000000, 1'b0, 4'd0, 4'd0, 8};
    rst = 1'b1;
    start = 1'b0;
    wr_en = 1'b0;
    word = '0;
    wr_addr = '0;
    wr_data = '0;
`ifdef VOCAB_MATCHER_PREFIX_EN
    prefix_mode = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_found", {31'd0, found}, 0);
    chk("rst_token", {28'd0, token_id}, 0);
    chk("rst_addr", {28'd0, match_addr}, 0);
    launch(24'h000061, 1'b0, 0, 0, 2);
    collect("empty_vocab", 1);
    load_ab_cd();
    for (int i = 0; i < 6; i++) begin
      launch(tbl[i].w, tbl[i].f, tbl[i].t, tbl[i].a, tbl[i].e);
      collect(tbl[i].nm, 1);
    end
`ifdef VOCAB_MATCHER_PREFIX_EN
    prefix_mode = 1'b1;
    launch(24'h000063, 1'b1, 1, 3, 6);
    collect("prefix_c", 1);
    prefix_mode = 1'b0;
    launch(24'h000063, 1'b0, 0, 0, 8);
    collect("exact_c", 1);
`else
    launch(24'h000063, 1'b0, 0, 0, 8);
    collect("exact_c", 1);
`endif
    launch(24'h006463, 1'b1, 1, 3, 7);
    @(posedge clk);
    #1 start = 1'b1;
    word = 24'h006261;
    wr_en = 1'b1;
    wr_addr = 4'd3;
    wr_data = 8'h71;
    @(posedge clk);
    #1 start = 1'b0;
    wr_en = 1'b0;
    collect("busy_ignore", 3);
    launch(24'h006463, 1'b1, 1, 3, 7);
    collect("vocab_kept", 1);
    for (int i = 0; i < DEPTH; i++) wr(AW'(i), 8'h78);
    launch(24'h007a7a, 1'b0, 0, 0, 17);
    collect("full_nowrap", 1);
    launch(24'h007a7a, 1'b0, 0, 0, 17);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    sb.delete();
    held_t = '0;
    held_a = '0;
    chk("midrst_busy", {31'd0, busy}, 0);
    chk("midrst_done", {31'd0, done}, 0);
    chk("midrst_found", {31'd0, found}, 0);
    chk("midrst_token", {28'd0, token_id}, 0);
    chk("midrst_addr", {28'd0, match_addr}, 0);
    @(posedge clk);
    #1 chk("midrst_idle", {31'd0, busy}, 0);
    launch(24'h000078, 1'b0, 0, 0, 2);
    collect("post_rst_cleared", 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
